// File: rtl/learn_sequencer_pkg.sv
// Shared types and constants for the learning-mode sequencer.
package learn_sequencer_pkg;

  localparam int unsigned NOTE_W    = 4;
  localparam logic [3:0]  NOTE_REST = 4'd0;
  localparam logic [4:0]  SCORE_MAX = 5'd31;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StLatch,
    StPrompt,
    StPlay,
    StGap,
    StDone
  } state_e;

  function automatic logic [4:0] score_inc(input logic [4:0] s);
    return (s == SCORE_MAX) ? s : s + 5'd1;
  endfunction

endpackage

// File: rtl/learn_sequencer_timer.sv
// Free-running up-counter with synchronous clear and a terminal-count compare.
module learn_sequencer_timer #(
  parameter int unsigned CNT_W = 30
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic [CNT_W-1:0] i_limit,
  output logic             o_hit
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_hit = (r_cnt == i_limit);

endmodule

// File: rtl/learn_sequencer.sv
// Learning-mode session sequencer: prompts each song note, waits for the key,
// plays the note for its stored duration and scores first-try hits.
module learn_sequencer
  import learn_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_W      = 5,
  parameter int unsigned SONG_MAX    = 25,
  parameter int unsigned DUR_W       = 26,
  parameter int unsigned GAP_CYCLES  = 50_000_000,
  parameter int unsigned TIMEOUT_CYC = 500_000_000,
  parameter int unsigned CNT_W       = 30
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [NOTE_W-1:0] i_user_input,
  output logic [ADDR_W-1:0] o_rom_addr,
  input  logic [NOTE_W-1:0] i_rom_note,
  input  logic [DUR_W-1:0]  i_rom_dur,
  output logic [NOTE_W-1:0] o_expected_note,
  output logic              o_key_on,
  output logic [NOTE_W-1:0] o_key,
  output logic [4:0]        o_score,
  output logic              o_wrong,
  output logic              o_busy,
  output logic              o_done
);

  state_e              r_state, w_state_d;
  logic [ADDR_W-1:0]   r_addr, w_addr_d;
  logic [4:0]          r_score, w_score_d;
  logic [NOTE_W-1:0]   r_note, w_note_d;
  logic [DUR_W-1:0]    r_dur, w_dur_d;
  logic                r_armed, w_armed_d;
  logic                r_first, w_first_d;
  logic                r_wrong, w_wrong_d;
  logic                r_key_on, w_key_on_d;
  logic [NOTE_W-1:0]   r_key, w_key_d;
  logic [NOTE_W-1:0]   r_exp, w_exp_d;

  logic                w_busy;
  logic                w_clr;
  logic                w_hit;
  logic [CNT_W-1:0]    w_limit;
  logic [DUR_W-1:0]    w_dur_eff;
  logic [ADDR_W:0]     w_addr_inc;
  logic                w_press;

  assign w_busy     = (r_state != StIdle) && (r_state != StDone);
  assign w_dur_eff  = (r_dur == '0) ? DUR_W'(1) : r_dur;
  assign w_addr_inc = (ADDR_W + 1)'(r_addr) + (ADDR_W + 1)'(1);
  assign w_press    = r_armed && (i_user_input != NOTE_REST);

  // Timer restarts on every state entry and rests while idle.
  assign w_clr = (w_state_d != r_state) || !w_busy;

  always_comb begin
    case (r_state)
      StPrompt: w_limit = CNT_W'(TIMEOUT_CYC - 1);
      StPlay:   w_limit = CNT_W'(w_dur_eff) - CNT_W'(1);
      StGap:    w_limit = CNT_W'(GAP_CYCLES - 1);
      default:  w_limit = '1;
    endcase
  end

  learn_sequencer_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_clr  (w_clr),
    .i_limit(w_limit),
    .o_hit  (w_hit)
  );

  always_comb begin
    w_state_d = r_state;
    w_addr_d  = r_addr;
    w_score_d = r_score;
    w_note_d  = r_note;
    w_dur_d   = r_dur;
    w_armed_d = r_armed;
    w_first_d = r_first;
    w_wrong_d = 1'b0;

    if (i_abort) begin
      w_state_d = StIdle;
      w_addr_d  = '0;
      w_armed_d = 1'b0;
    end else begin
      case (r_state)
        StIdle, StDone: begin
          if (i_start) begin
            w_state_d = StFetch;
            w_addr_d  = '0;
            w_score_d = '0;
          end
        end
        StFetch: w_state_d = StLatch;
        StLatch: begin
          w_note_d = i_rom_note;
          w_dur_d  = i_rom_dur;
          if (i_rom_note == NOTE_REST) begin
            w_state_d = StDone;
          end else begin
            w_state_d = StPrompt;
            w_armed_d = 1'b0;
            w_first_d = 1'b1;
          end
        end
        StPrompt: begin
          // A timeout swallows a simultaneous wrong press so wrong stays inside PROMPT.
          if (w_press && (i_user_input == r_note)) begin
            if (r_first) w_score_d = score_inc(r_score);
            w_state_d = StPlay;
          end else if (w_hit) begin
            w_state_d = StPlay;
          end else if (w_press) begin
            w_wrong_d = 1'b1;
            w_first_d = 1'b0;
            w_armed_d = 1'b0;
          end else if (i_user_input == NOTE_REST) begin
            w_armed_d = 1'b1;
          end
        end
        StPlay: begin
          if (w_hit) w_state_d = StGap;
        end
        StGap: begin
          if (w_hit) begin
            w_addr_d  = w_addr_inc[ADDR_W-1:0];
            w_state_d = (w_addr_inc == (ADDR_W + 1)'(SONG_MAX)) ? StDone : StFetch;
          end
        end
        default: w_state_d = StIdle;
      endcase
    end

    w_key_on_d = (w_state_d == StPlay);
    w_key_d    = w_key_on_d ? w_note_d : NOTE_REST;
    w_exp_d    = (w_state_d == StPrompt) ? w_note_d : NOTE_REST;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state  <= StIdle;
      r_addr   <= '0;
      r_score  <= '0;
      r_note   <= '0;
      r_dur    <= '0;
      r_armed  <= 1'b0;
      r_first  <= 1'b0;
      r_wrong  <= 1'b0;
      r_key_on <= 1'b0;
      r_key    <= '0;
      r_exp    <= '0;
    end else begin
      r_state  <= w_state_d;
      r_addr   <= w_addr_d;
      r_score  <= w_score_d;
      r_note   <= w_note_d;
      r_dur    <= w_dur_d;
      r_armed  <= w_armed_d;
      r_first  <= w_first_d;
      r_wrong  <= w_wrong_d;
      r_key_on <= w_key_on_d;
      r_key    <= w_key_d;
      r_exp    <= w_exp_d;
    end
  end

  assign o_rom_addr      = r_addr;
  assign o_expected_note = r_exp;
  assign o_key_on        = r_key_on;
  assign o_key           = r_key;
  assign o_score         = r_score;
  assign o_wrong         = r_wrong;
  assign o_busy          = w_busy;
  assign o_done          = (r_state == StDone);

endmodule

// File: tb/tb_learn_sequencer.sv
// Directed + randomized session bench for learn_sequencer with a note-level player model.
module tb_learn_sequencer;

  localparam int unsigned GAP = 4;
  localparam int unsigned TMO = 20;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [3:0]  user_input;
  logic [4:0]  rom_addr;
  logic [3:0]  rom_note;
  logic [25:0] rom_dur;
  logic [3:0]  expected_note;
  logic        key_on;
  logic [3:0]  key;
  logic [4:0]  score;
  logic        wrong;
  logic        busy;
  logic        done;

  learn_sequencer #(
    .GAP_CYCLES (GAP),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_start        (start),
    .i_abort        (abort),
    .i_user_input   (user_input),
    .o_rom_addr     (rom_addr),
    .i_rom_note     (rom_note),
    .i_rom_dur      (rom_dur),
    .o_expected_note(expected_note),
    .o_key_on       (key_on),
    .o_key          (key),
    .o_score        (score),
    .o_wrong        (wrong),
    .o_busy         (busy),
    .o_done         (done)
  );

  always #5 clk = ~clk;

  // Song memory with one cycle of read latency.
  logic [3:0]  mem_note [32];
  logic [25:0] mem_dur  [32];
  int          plan_a   [32];

  always @(posedge clk) begin
    rom_note <= mem_note[rom_addr];
    rom_dur  <= mem_dur[rom_addr];
  end

  int n_pass = 0;
  int n_total = 0;
  int exp_score;
  int exp_wrong;
  int wrong_cnt = 0;
  int bad_addr = 0;
  int run_len = 0;
  logic [3:0] last_key;
  int q_run[$];
  logic [3:0] q_key[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Observe key_on runs, wrong pulses and address range just after each edge.
  always @(posedge clk) begin
    #1;
    if (key_on) begin
      run_len++;
      last_key = key;
    end else if (run_len != 0) begin
      q_run.push_back(run_len);
      q_key.push_back(last_key);
      run_len = 0;
    end
    if (wrong) begin
      wrong_cnt++;
      check("wrong_only_prompting", 32'(expected_note != 4'd0), 32'd1);
    end
    if (rom_addr > 5'd25) bad_addr++;
  end

  task automatic wait_sig(input int sel, input int limit, input string tag);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < limit && !hit; i++) begin
      @(negedge clk);
      case (sel)
        0: hit = (expected_note != 4'd0);
        1: hit = key_on;
        2: hit = !key_on;
        default: hit = done;
      endcase
    end
    check(tag, 32'(hit), 32'd1);
  endtask

  // plan: 0 clean press, 1 wrong key first, 2 no input (timeout), 3 key held into prompt
  task automatic play_note(input logic [3:0] note, input int dur, input int plan);
    logic [3:0] w;
    int r;
    logic [3:0] k;
    if (plan == 3) user_input = note;
    wait_sig(0, 300, "prompt_seen");
    check("prompt_note", 32'(expected_note), 32'(note));
    case (plan)
      0: begin
        @(negedge clk);
        user_input = note;
      end
      1: begin
        w = 4'(((int'(note) - 1 + int'($urandom_range(1, 14))) % 15) + 1);
        @(negedge clk);
        user_input = w;
        @(negedge clk);
        user_input = 4'd0;
        repeat (2) @(negedge clk);
        user_input = note;
        exp_wrong++;
      end
      2: ;
      default: begin
        repeat (4) @(negedge clk);
        check("held_not_accepted", 32'(key_on), 32'd0);
        user_input = 4'd0;
        @(negedge clk);
        user_input = note;
      end
    endcase
    if (plan == 0 || plan == 3) exp_score = (exp_score >= 31) ? 31 : exp_score + 1;
    wait_sig(1, TMO + 10, "key_on_rise");
    user_input = 4'd0;
    wait_sig(2, dur + 10, "key_on_fall");
    check("run_present", 32'(q_run.size()), 32'd1);
    if (q_run.size() > 0) begin
      r = q_run.pop_front();
      k = q_key.pop_front();
      check("run_len", 32'(r), 32'((dur == 0) ? 1 : dur));
      check("run_key", 32'(k), 32'(note));
    end
  endtask

  task automatic run_session(input int n);
    exp_score = 0;
    exp_wrong = 0;
    wrong_cnt = 0;
    q_run.delete();
    q_key.delete();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    for (int i = 0; i < n; i++) play_note(mem_note[i], int'(mem_dur[i]), plan_a[i]);
    wait_sig(3, GAP + 20, "done_seen");
    check("done", 32'(done), 32'd1);
    check("busy_at_done", 32'(busy), 32'd0);
    check("score", 32'(score), 32'(exp_score));
    check("wrong_count", 32'(wrong_cnt), 32'(exp_wrong));
    check("final_addr", 32'(rom_addr), 32'((n < 25) ? n : 25));
    check("exp_note_idle", 32'(expected_note), 32'd0);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 32; i++) begin
      mem_note[i] = 4'd0;
      mem_dur[i]  = 26'd0;
      plan_a[i]   = 0;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    user_input = 4'd0;
    clear_mem();
    repeat (3) @(negedge clk);
    check("rst_addr", 32'(rom_addr), 32'd0);
    check("rst_key_on", 32'(key_on), 32'd0);
    check("rst_key", 32'(key), 32'd0);
    check("rst_exp", 32'(expected_note), 32'd0);
    check("rst_score", 32'(score), 32'd0);
    check("rst_flags", 32'({wrong, busy, done}), 32'd0);
    rst_n = 1'b1;

    // Two clean notes.
    mem_note[0] = 4'd3; mem_dur[0] = 26'd5;
    mem_note[1] = 4'd7; mem_dur[1] = 26'd2;
    run_session(2);

    // Wrong key first, then correct: no score.
    clear_mem();
    mem_note[0] = 4'd3; mem_dur[0] = 26'd4; plan_a[0] = 1;
    run_session(1);

    // Key held across entry into the prompt for a repeated note.
    clear_mem();
    mem_note[0] = 4'd3; mem_dur[0] = 26'd3;
    mem_note[1] = 4'd3; mem_dur[1] = 26'd2; plan_a[1] = 3;
    run_session(2);

    // No input: note is demonstrated after the timeout.
    clear_mem();
    mem_note[0] = 4'd6; mem_dur[0] = 26'd3; plan_a[0] = 2;
    mem_note[1] = 4'd9; mem_dur[1] = 26'd1;
    run_session(2);

    // Full-length song, all clean, random notes and durations (0 plays one cycle).
    clear_mem();
    for (int i = 0; i < 26; i++) begin
      mem_note[i] = 4'($urandom_range(1, 15));
      mem_dur[i]  = 26'($urandom_range(0, 6));
    end
    run_session(25);
    check("addr_bound", 32'(bad_addr), 32'd0);

    // Random session with random player behaviour.
    clear_mem();
    for (int i = 0; i < 10; i++) begin
      mem_note[i] = 4'($urandom_range(1, 15));
      mem_dur[i]  = 26'($urandom_range(0, 7));
      plan_a[i]   = int'($urandom_range(0, 3));
    end
    run_session(10);

    // Abort mid-PLAY.
    clear_mem();
    mem_note[0] = 4'd9; mem_dur[0] = 26'd12;
    mem_note[1] = 4'd2; mem_dur[1] = 26'd3;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_sig(0, 50, "abort_prompt_seen");
    @(negedge clk);
    user_input = 4'd9;
    wait_sig(1, 10, "abort_key_on_rise");
    user_input = 4'd0;
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_key_on", 32'(key_on), 32'd0);
    check("abort_key", 32'(key), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_addr", 32'(rom_addr), 32'd0);
    check("abort_score_held", 32'(score), 32'd1);

    // Reset asserted during GAP.
    exp_score = 0;
    q_run.delete();
    q_key.delete();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    play_note(4'd9, 12, 0);
    rst_n = 1'b0;
    @(negedge clk);
    check("gap_rst_addr", 32'(rom_addr), 32'd0);
    check("gap_rst_score", 32'(score), 32'd0);
    check("gap_rst_out", 32'({key_on, key, expected_note}), 32'd0);
    check("gap_rst_flags", 32'({wrong, busy, done}), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
